seg7_display_driver: RTL and testbench

Output-side counterpart to the keypad scanner. It accepts an 8-bit calculator result (operand echo or ALU output), converts it to sign plus three BCD digits with a sequential double-dabble, and drives a 4-digit multiplexed seven-segment display. It sits between the calculator datapath/control FSM and the board's segment and anode pins.

---
 rtl/seg7_display_driver.sv | 165 ++++++++++++++++
 tb/tb_seg7_display_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_driver.sv
// 8-bit result to sign + 3-digit BCD (sequential double-dabble),
// driven onto a 4-digit multiplexed active-low seven-segment display.
module seg7_display_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       is_signed,
  input  logic       err,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  state_t       state;
  logic [19:0]  sr;
  logic [2:0]   bit_cnt;
  logic         neg_q;
  logic         err_q;
  logic [6:0]   disp [4];

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;

  logic         neg_in;
  logic [7:0]   mag;
  logic [19:0]  adj;
  logic [19:0]  next_sr;
  logic [3:0]   hund;
  logic [3:0]   tens;
  logic [3:0]   ones;
  logic [6:0]   new_d3;
  logic [6:0]   new_d2;
  logic [6:0]   new_d1;
  logic [6:0]   new_d0;

  // 0x80 signed negates to 0x80, which is 128 unsigned: 8 bits suffice.
  always_comb begin
    neg_in = is_signed & value[7];
    mag    = neg_in ? (~value + 8'd1) : value;
  end

  always_comb begin
    adj = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};
    next_sr = {adj[18:0], 1'b0};
  end

  always_comb begin
    hund = sr[19:16];
    tens = sr[15:12];
    ones = sr[11:8];
    if (err_q) begin
      new_d3 = SEG_E;
      new_d2 = SEG_R;
      new_d1 = SEG_R;
      new_d0 = SEG_BLANK;
    end else begin
      new_d3 = neg_q ? SEG_MINUS : SEG_BLANK;
      new_d2 = (hund != 4'd0) ? digit_seg(hund) : SEG_BLANK;
      new_d1 = (hund != 4'd0 || tens != 4'd0) ? digit_seg(tens)
                                              : SEG_BLANK;
      new_d0 = digit_seg(ones);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      sr      <= '0;
      bit_cnt <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      disp[0] <= SEG_BLANK;
      disp[1] <= SEG_BLANK;
      disp[2] <= SEG_BLANK;
      disp[3] <= SEG_BLANK;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            sr      <= {12'd0, mag};
            bit_cnt <= '0;
            neg_q   <= neg_in;
            err_q   <= err;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          sr      <= next_sr;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          disp[3] <= new_d3;
          disp[2] <= new_d2;
          disp[1] <= new_d1;
          disp[0] <= new_d0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan runs independently of conversion; outputs lag index by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= 4'b1110;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == TC) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      an  <= ~(4'b0001 << idx);
      seg <= disp[idx];
    end
  end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Randomized bench for seg7_display_driver against an arithmetic
// model of the displayed digits, busy window and scan position.
module tb_seg7_display_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic       is_signed = 1'b0;
  logic       err = 1'b0;
  logic       load = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  seg7_display_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .is_signed(is_signed),
    .err(err),
    .load(load),
    .busy(busy),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit          started = 1'b0;
  int          k;
  int          busy_left;
  int          mi;
  logic [7:0]  c_val;
  bit          c_sgn;
  bit          c_err;
  logic [27:0] mdisp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_busy;

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // Digits 3..0 packed as {d3,d2,d1,d0}.
  function automatic logic [27:0] render(input logic [7:0] v,
                                         input bit s, input bit e);
    int m, h, t, o;
    logic [6:0] d3, d2, d1, d0;
    if (e) return {7'h06, 7'h2F, 7'h2F, 7'h7F};
    m = (s && v[7]) ? 256 - int'(v) : int'(v);
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    d3 = (s && v[7]) ? 7'h3F : 7'h7F;
    d2 = (h != 0) ? dig(h) : 7'h7F;
    d1 = (h != 0 || t != 0) ? dig(t) : 7'h7F;
    d0 = dig(o);
    return {d3, d2, d1, d0};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started   = 1'b1;
      k         = 0;
      busy_left = 0;
      mdisp     = {4{7'h7F}};
      exp_an    = 4'b1110;
      exp_seg   = 7'h7F;
      exp_busy  = 1'b0;
    end else begin
      mi      = (k / SD) % 4;
      exp_an  = ~(4'b0001 << mi);
      exp_seg = mdisp[mi*7 +: 7];
      k++;
      if (busy_left == 0) begin
        if (load) begin
          c_val     = value;
          c_sgn     = is_signed;
          c_err     = err;
          busy_left = 9;
        end
      end else begin
        busy_left--;
        if (busy_left == 0) mdisp = render(c_val, c_sgn, c_err);
      end
      exp_busy = (busy_left > 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("busy", 32'(busy), 32'(exp_busy));
    end
  end

  task automatic do_load(input logic [7:0] v, input bit s, input bit e);
    value     = v;
    is_signed = s;
    err       = e;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic settle();
    repeat (12 + 4 * SD) @(negedge clk);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'h0000000E);
    check("rst_seg", 32'(seg), 32'h0000007F);
    rst = 1'b0;
    repeat (4 * SD + 4) @(negedge clk);

    do_load(8'h7B, 1'b0, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", 32'(n), 32'd9);
    repeat (4 * SD + 2) @(negedge clk);
    check("pin_123", 32'(mdisp), 32'({7'h7F, 7'h79, 7'h24, 7'h30}));

    do_load(8'h80, 1'b1, 1'b0);
    settle();
    check("pin_m128", 32'(mdisp), 32'({7'h3F, 7'h79, 7'h24, 7'h00}));
    do_load(8'h05, 1'b0, 1'b0);
    settle();
    check("pin_5", 32'(mdisp), 32'({7'h7F, 7'h7F, 7'h7F, 7'h12}));
    do_load(8'h00, 1'b0, 1'b0);
    settle();
    check("pin_0", 32'(mdisp), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    do_load(8'hFF, 1'b1, 1'b0);
    settle();
    check("pin_m1", 32'(mdisp), 32'({7'h3F, 7'h7F, 7'h7F, 7'h79}));

    do_load(8'h7B, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    do_load(8'h00, 1'b0, 1'b1);
    settle();
    check("pin_drop", 32'(mdisp), 32'({7'h7F, 7'h79, 7'h24, 7'h30}));
    do_load(8'h00, 1'b0, 1'b1);
    settle();
    check("pin_err", 32'(mdisp), 32'({7'h06, 7'h2F, 7'h2F, 7'h7F}));

    do_load(8'h7B, 1'b0, 1'b0);
    settle();
    do_load(8'hFF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("pin_abort", 32'(mdisp), 32'({4{7'h7F}}));

    for (int i = 0; i < 40; i++) begin
      do_load(8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
